// File: rtl/pcm_to_pwm_mc.sv
// Multi-channel PCM-to-PWM DAC with a one-deep frame buffer.
// New duty codes take effect only at PWM period boundaries.
module pcm_to_pwm_mc #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned DW     = 16,
    parameter int unsigned RES    = 8,
    parameter int unsigned CLKDIV = 1,
    parameter int unsigned CENTER = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NCH*DW-1:0]   in_data,
    output logic [NCH-1:0]      pwm_out,
    output logic                period_start,
    output logic                underrun
);

    localparam int unsigned      PSC_W    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLKDIV - 1);
    localparam logic [RES-1:0]   CNT_MAX  = {RES{1'b1}};
    localparam logic [RES-1:0]   DUTY_MID = RES'(1) << (RES - 1);

    // Triangle counter direction
    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

    logic [PSC_W-1:0]         psc_q, psc_d;
    logic [RES-1:0]           cnt_q, cnt_d;
    logic [0:0]               dir_q, dir_d;
    logic [NCH-1:0][RES-1:0]  duty_q, duty_d;
    logic [NCH-1:0][RES-1:0]  pend_q, pend_d;
    logic                     full_q, full_d;
    logic [NCH-1:0][RES-1:0]  in_code;
    logic [NCH-1:0]           pwm_d;
    logic                     tick_c;
    logic                     bnd_c;
    logic                     xfer_c;
    logic                     underrun_d;

    // Signed sample to offset binary, keeping the top RES bits
    function automatic logic [RES-1:0] to_code(input logic [DW-1:0] s);
        logic [DW-1:0] ob;
        ob         = s;
        ob[DW-1]   = ~s[DW-1];
        return ob[DW-1 -: RES];
    endfunction

    assign in_ready = ~full_q;

    // Duty codes of the frame currently on in_data
    always_comb begin
        in_code = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            in_code[k] = to_code(in_data[k*DW +: DW]);
        end
    end

    // Next-state: prescaler, counter/direction, buffer, duties and outputs
    always_comb begin
        psc_d      = psc_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        duty_d     = duty_q;
        pend_d     = pend_q;
        full_d     = full_q;
        underrun_d = 1'b0;
        pwm_d      = '0;

        tick_c = (psc_q == PSC_LAST);
        xfer_c = in_valid & ~full_q;
        psc_d  = tick_c ? '0 : psc_q + PSC_W'(1);

        if (tick_c) begin
            if (CENTER == 0) begin
                cnt_d = cnt_q + RES'(1);
            end else begin
                if (dir_q == DIR_UP) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q - RES'(1) : cnt_q + RES'(1);
                end else begin
                    cnt_d = cnt_q - RES'(1);
                end
                if (cnt_d == '0) begin
                    dir_d = DIR_UP;
                end else if (dir_q == DIR_UP && cnt_q == CNT_MAX) begin
                    dir_d = DIR_DOWN;
                end
            end
        end

        bnd_c = tick_c & (cnt_d == '0);

        if (bnd_c) begin
            if (full_q) begin
                duty_d = pend_q;
                full_d = 1'b0;
            end else if (xfer_c) begin
                duty_d = in_code;
            end else begin
                underrun_d = 1'b1;
            end
        end else if (xfer_c) begin
            pend_d = in_code;
            full_d = 1'b1;
        end

        for (int k = 0; k < int'(NCH); k++) begin
            pwm_d[k] = (cnt_d < duty_d[k]);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q        <= '0;
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            duty_q       <= {NCH{DUTY_MID}};
            pend_q       <= '0;
            full_q       <= 1'b0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            psc_q        <= psc_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            duty_q       <= duty_d;
            pend_q       <= pend_d;
            full_q       <= full_d;
            pwm_out      <= pwm_d;
            period_start <= bnd_c;
            underrun     <= underrun_d;
        end
    end

endmodule

// File: tb/tb_pcm_to_pwm_mc.sv
// Scoreboard bench: an edge-aligned and a centre-aligned instance run side by side.
module tb_pcm_to_pwm_mc;

    localparam int unsigned NCH = 2;
    localparam int unsigned DW  = 16;
    localparam int unsigned RES = 4;

    typedef struct packed {
        logic           idx;
        logic [NCH-1:0] pwm;
        logic           ps;
        logic           ur;
        logic           rdy;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              v0, v1;
    logic [NCH*DW-1:0] d0, d1;
    logic              rdy0, rdy1;
    logic [NCH-1:0]    pwm0, pwm1;
    logic              ps0, ps1, ur0, ur1;

    int errors = 0;
    int checks = 0;

    exp_t q[$];

    int unsigned    e_cnt [2];
    bit             pend  [2];
    logic [RES-1:0] pcode [2][NCH];
    logic [RES-1:0] duty  [2][NCH];

    pcm_to_pwm_mc #(.NCH(NCH), .DW(DW), .RES(RES), .CLKDIV(1), .CENTER(0)) u_edge (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
        .pwm_out(pwm0), .period_start(ps0), .underrun(ur0)
    );

    pcm_to_pwm_mc #(.NCH(NCH), .DW(DW), .RES(RES), .CLKDIV(3), .CENTER(1)) u_ctr (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .pwm_out(pwm1), .period_start(ps1), .underrun(ur1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned cdiv(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int unsigned per(input int i);
        return (i == 0) ? (1 << RES) : (2 * (1 << RES) - 2);
    endfunction

    // True when clk edge number e (counted from reset release) is a period boundary
    function automatic bit is_bnd(input int i, input int unsigned e);
        if (e == 0) return 1'b0;
        return (e % cdiv(i) == 0) && (((e / cdiv(i)) % per(i)) == 0);
    endfunction

    // Counter value after n ticks, from position within the period
    function automatic int unsigned cnt_of(input int i, input int unsigned n);
        int unsigned m;
        m = n % per(i);
        if (i == 0) return m;
        return (m < (1 << RES)) ? m : per(i) - m;
    endfunction

    function automatic logic [RES-1:0] code_of(input logic [DW-1:0] s);
        int v;
        v = int'($signed(s)) + (1 << (DW - 1));
        return RES'(v / (1 << (DW - RES)));
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            e_cnt[i] = 0;
            pend[i]  = 1'b0;
            for (int k = 0; k < int'(NCH); k++) begin
                duty[i][k]  = RES'(1 << (RES - 1));
                pcode[i][k] = '0;
            end
        end
        q.delete();
    endtask

    // Reference model: one clk edge for instance i, pushes expected outputs
    task automatic step(input int i);
        logic              vin;
        logic [NCH*DW-1:0] din;
        bit                bnd, xfer, ur;
        int unsigned       cnt;
        exp_t              x;
        vin = (i == 0) ? v0 : v1;
        din = (i == 0) ? d0 : d1;
        e_cnt[i]++;
        bnd  = is_bnd(i, e_cnt[i]);
        xfer = vin && !pend[i];
        ur   = 1'b0;
        if (bnd) begin
            if (pend[i]) begin
                for (int k = 0; k < int'(NCH); k++) duty[i][k] = pcode[i][k];
                pend[i] = 1'b0;
            end else if (xfer) begin
                for (int k = 0; k < int'(NCH); k++) duty[i][k] = code_of(din[k*DW +: DW]);
            end else begin
                ur = 1'b1;
            end
        end else if (xfer) begin
            for (int k = 0; k < int'(NCH); k++) pcode[i][k] = code_of(din[k*DW +: DW]);
            pend[i] = 1'b1;
        end
        cnt = cnt_of(i, e_cnt[i] / cdiv(i));
        x.idx = (i != 0);
        for (int k = 0; k < int'(NCH); k++) x.pwm[k] = (cnt < int'(duty[i][k]));
        x.ps  = bnd;
        x.ur  = ur;
        x.rdy = !pend[i];
        q.push_back(x);
    endtask

    // Model advances on every active edge out of reset
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) begin
                step(0);
                step(1);
            end
        end
    end

    // Monitor: compare DUT outputs against queued expectations
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                x = q.pop_front();
                if (x.idx == 1'b0) begin
                    chk("pwm_out", 0, 32'(pwm0), 32'(x.pwm));
                    chk("period_start", 0, 32'(ps0), 32'(x.ps));
                    chk("underrun", 0, 32'(ur0), 32'(x.ur));
                    chk("in_ready", 0, 32'(rdy0), 32'(x.rdy));
                end else begin
                    chk("pwm_out", 1, 32'(pwm1), 32'(x.pwm));
                    chk("period_start", 1, 32'(ps1), 32'(x.ps));
                    chk("underrun", 1, 32'(ur1), 32'(x.ur));
                    chk("in_ready", 1, 32'(rdy1), 32'(x.rdy));
                end
            end
        end
    end

    function automatic logic [NCH*DW-1:0] rand_frame();
        logic [NCH*DW-1:0] f;
        logic [DW-1:0]     tbl [7];
        tbl = '{16'h0000, 16'h7FFF, 16'h8000, 16'h7000, 16'hFFFF, 16'h0FFF, 16'h8FFF};
        for (int k = 0; k < int'(NCH); k++) begin
            if ($urandom_range(0, 1) == 0) f[k*DW +: DW] = tbl[$urandom_range(0, 6)];
            else                           f[k*DW +: DW] = DW'($urandom);
        end
        return f;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pwm"}, 0, 32'(pwm0), 32'd0);
        chk({tag, "_pwm"}, 1, 32'(pwm1), 32'd0);
        chk({tag, "_ps"},  0, 32'(ps0),  32'd0);
        chk({tag, "_ps"},  1, 32'(ps1),  32'd0);
        chk({tag, "_ur"},  0, 32'(ur0),  32'd0);
        chk({tag, "_ur"},  1, 32'(ur1),  32'd0);
        chk({tag, "_rdy"}, 0, 32'(rdy0), 32'd1);
        chk({tag, "_rdy"}, 1, 32'(rdy1), 32'd1);
    endtask

    // Offer one frame to both instances, holding valid until each accepts (bounded)
    task automatic send_both(input logic [NCH*DW-1:0] f);
        bit acc0, acc1;
        acc0 = 1'b0;
        acc1 = 1'b0;
        v0 = 1'b1; v1 = 1'b1; d0 = f; d1 = f;
        for (int t = 0; t < 400; t++) begin
            if (v0 && rdy0) acc0 = 1'b1;
            if (v1 && rdy1) acc1 = 1'b1;
            @(negedge clk);
            if (acc0) v0 = 1'b0;
            if (acc1) v1 = 1'b0;
            if (acc0 && acc1) break;
        end
        v0 = 1'b0; v1 = 1'b0;
        chk("send_accepted", 0, 32'(acc0), 32'd1);
        chk("send_accepted", 1, 32'(acc1), 32'd1);
    endtask

    task automatic idle(input int n);
        v0 = 1'b0; v1 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Random traffic; mode 0 dense, 1 sparse, 2 only on boundary clks, 3 starved
    task automatic run_random(input int mode, input int n);
        bit v;
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                case (mode)
                    0:       v = ($urandom_range(0, 3) != 0);
                    1:       v = ($urandom_range(0, 19) == 0);
                    2:       v = is_bnd(i, e_cnt[i] + 1) && ($urandom_range(0, 1) == 1);
                    default: v = 1'b0;
                endcase
                if (i == 0) begin v0 = v; d0 = rand_frame(); end
                else        begin v1 = v; d1 = rand_frame(); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        #6;
        rst_n = 1'b1;
        @(negedge clk);

        // ch0 = 0 (midscale), ch1 = full positive
        send_both({16'h7FFF, 16'h0000});
        idle(100);
        // ch0 = most negative (constant low), ch1 = code 15
        send_both({16'h7000, 16'h8000});
        idle(200);

        for (int ph = 0; ph < 8; ph++) run_random(ph % 4, 300);

        // Reset mid-period with a high duty live
        send_both({16'h7FFF, 16'h7FFF});
        idle(200);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        #20;
        rst_n = 1'b1;
        idle(150);
        run_random(0, 300);
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
